// File: rtl/ctrl_pkg.sv
// Shared definitions for the controller: opcodes, state and class encodings,
// ACC source select codes and fault codes.
package ctrl_pkg;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_NOR  = 4'b0011;
    localparam logic [3:0] OP_MOVR = 4'b0100;
    localparam logic [3:0] OP_MOVA = 4'b0101;
    localparam logic [3:0] OP_JZRS = 4'b0110;
    localparam logic [3:0] OP_JZIM = 4'b0111;
    localparam logic [3:0] OP_JCRS = 4'b1000;
    localparam logic [3:0] OP_JCIM = 4'b1010;
    localparam logic [3:0] OP_SHL  = 4'b1011;
    localparam logic [3:0] OP_SHR  = 4'b1100;
    localparam logic [3:0] OP_LDIM = 4'b1101;
    localparam logic [3:0] OP_HALT = 4'b1111;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_JUMP   = 3'd3,
        ST_ACC    = 3'd4,
        ST_REG    = 3'd5,
        ST_HALT   = 3'd6,
        ST_FAULT  = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        CLS_NOP  = 3'd0,
        CLS_ACC  = 3'd1,
        CLS_REG  = 3'd2,
        CLS_JZ   = 3'd3,
        CLS_JC   = 3'd4,
        CLS_HALT = 3'd5,
        CLS_ILL  = 3'd6
    } op_class_t;

    localparam logic [1:0] SELACC_ALU = 2'b00;
    localparam logic [1:0] SELACC_REG = 2'b10;
    localparam logic [1:0] SELACC_IMM = 2'b11;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    // Timeout counter width; TMO never exceeds 255.
    localparam int TMO_W = 8;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier: instruction class, legality,
// PC source for jumps and ACC source for ACC-class ops.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OP_W = 4
) (
    input  logic [OP_W-1:0] op,
    output logic [2:0]      cls,
    output logic            sel_pc,
    output logic [1:0]      sel_acc
);

    logic      hi_nz;
    op_class_t cls_d;

    // Any set bit above the 4-bit opcode field makes the op illegal.
    assign hi_nz = (op >> 4) != '0;
    assign cls   = cls_d;

    // Classify the low nibble; jumps with register targets select PC source 1.
    always_comb begin
        cls_d   = CLS_ILL;
        sel_pc  = 1'b0;
        sel_acc = SELACC_ALU;
        if (!hi_nz) begin
            case (op[3:0])
                OP_ADD, OP_SUB, OP_NOR, OP_SHL, OP_SHR: cls_d = CLS_ACC;
                OP_MOVR: begin
                    cls_d   = CLS_ACC;
                    sel_acc = SELACC_REG;
                end
                OP_LDIM: begin
                    cls_d   = CLS_ACC;
                    sel_acc = SELACC_IMM;
                end
                OP_MOVA: cls_d = CLS_REG;
                OP_JZRS: begin
                    cls_d  = CLS_JZ;
                    sel_pc = 1'b1;
                end
                OP_JZIM: cls_d = CLS_JZ;
                OP_JCRS: begin
                    cls_d  = CLS_JC;
                    sel_pc = 1'b1;
                end
                OP_JCIM: cls_d = CLS_JC;
                OP_NOP:  cls_d = CLS_NOP;
                OP_HALT: cls_d = CLS_HALT;
                default: cls_d = CLS_ILL;
            endcase
        end
    end

endmodule

// File: rtl/controller_v2.sv
// Multi-cycle CPU control unit: fetch with timeout, decode, one execute
// cycle, terminal HALT/FAULT, and a retired-instruction counter.
//
//   state  | meaning
//   INIT   | one idle cycle after reset
//   FETCH  | request instruction, wait for mem_ack (bounded by TMO)
//   DECODE | classify op, sample z/c
//   JUMP   | load PC from register or immediate
//   ACC    | load ACC from ALU/Reg/Imm
//   REG    | load Reg from ACC
//   HALT   | terminal, halted=1
//   FAULT  | terminal, fault code held
module controller_v2
    import ctrl_pkg::*;
#(
    parameter int OP_W  = 4,
    parameter int ALU_W = 4,
    parameter int TMO   = 15,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             CLB,
    input  logic             z,
    input  logic             c,
    input  logic [OP_W-1:0]  op,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             LoadIR,
    output logic             IncPC,
    output logic             SelPC,
    output logic             LoadPC,
    output logic             LoadReg,
    output logic             LoadAcc,
    output logic [1:0]       SelAcc,
    output logic [ALU_W-1:0] SelALU,
    output logic             halted,
    output logic [1:0]       fault,
    output logic [CNT_W-1:0] retired
);

    state_t           state_q;
    state_t           state_d;
    logic [TMO_W-1:0] tmo_q;
    logic [CNT_W-1:0] retired_q;
    logic [1:0]       fault_code_q;
    logic [1:0]       fault_code_d;
    logic             retire_en;
    logic [2:0]       cls_raw;
    op_class_t        cls;
    logic             sel_pc;
    logic [1:0]       sel_acc;

    ctrl_decode #(
        .OP_W(OP_W)
    ) u_decode (
        .op      (op),
        .cls     (cls_raw),
        .sel_pc  (sel_pc),
        .sel_acc (sel_acc)
    );

    assign cls     = op_class_t'(cls_raw);
    assign retired = retired_q;

    // State register.
    always_ff @(posedge clk or negedge CLB) begin
        if (!CLB) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Fetch timeout counter, retired counter and latched fault code.
    always_ff @(posedge clk or negedge CLB) begin
        if (!CLB) begin
            tmo_q        <= '0;
            retired_q    <= '0;
            fault_code_q <= FAULT_NONE;
        end else begin
            // Held at zero outside FETCH so every FETCH entry starts from 0.
            if (state_q != ST_FETCH) begin
                tmo_q <= '0;
            end else if (!mem_ack) begin
                tmo_q <= tmo_q + TMO_W'(1);
            end
            if (retire_en) begin
                retired_q <= retired_q + CNT_W'(1);
            end
            fault_code_q <= fault_code_d;
        end
    end

    // Next-state, retire and fault-capture decisions.
    always_comb begin
        state_d      = state_q;
        retire_en    = 1'b0;
        fault_code_d = fault_code_q;
        case (state_q)
            ST_INIT: state_d = ST_FETCH;
            ST_FETCH: begin
                // An ack in the final allowed cycle still wins over the timeout.
                if (mem_ack) begin
                    state_d = ST_DECODE;
                end else if (tmo_q == TMO_W'(TMO)) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FAULT_TIMEOUT;
                end
            end
            ST_DECODE: begin
                case (cls)
                    CLS_ACC: state_d = ST_ACC;
                    CLS_REG: state_d = ST_REG;
                    CLS_JZ: begin
                        if (z) begin
                            state_d = ST_JUMP;
                        end else begin
                            state_d   = ST_FETCH;
                            retire_en = 1'b1;
                        end
                    end
                    CLS_JC: begin
                        if (c) begin
                            state_d = ST_JUMP;
                        end else begin
                            state_d   = ST_FETCH;
                            retire_en = 1'b1;
                        end
                    end
                    CLS_NOP: begin
                        state_d   = ST_FETCH;
                        retire_en = 1'b1;
                    end
                    CLS_HALT: begin
                        state_d   = ST_HALT;
                        retire_en = 1'b1;
                    end
                    default: begin
                        state_d      = ST_FAULT;
                        fault_code_d = FAULT_ILLEGAL;
                    end
                endcase
            end
            ST_JUMP, ST_ACC, ST_REG: begin
                state_d   = ST_FETCH;
                retire_en = 1'b1;
            end
            ST_HALT:  state_d = ST_HALT;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_INIT;
        endcase
    end

    // Datapath strobes and status outputs, decoded from the current state.
    always_comb begin
        mem_req = 1'b0;
        LoadIR  = 1'b0;
        IncPC   = 1'b0;
        SelPC   = 1'b0;
        LoadPC  = 1'b0;
        LoadReg = 1'b0;
        LoadAcc = 1'b0;
        SelAcc  = SELACC_ALU;
        SelALU  = '0;
        halted  = 1'b0;
        fault   = FAULT_NONE;
        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                LoadIR  = mem_ack;
                IncPC   = mem_ack;
            end
            ST_JUMP: begin
                LoadPC = 1'b1;
                SelPC  = sel_pc;
            end
            ST_ACC: begin
                LoadAcc = 1'b1;
                SelAcc  = sel_acc;
                SelALU  = ALU_W'(op);
            end
            ST_REG:   LoadReg = 1'b1;
            ST_HALT:  halted  = 1'b1;
            ST_FAULT: fault   = fault_code_q;
            default: ;
        endcase
    end

endmodule

// File: doc/controller_v2.md
CONTROLLER_V2 -- requirements
Module: controller_v2

Interface
REQ-001 Parameter OP_W, default 4: opcode width; SHALL be at least 4.
REQ-002 Parameter ALU_W, default 4: SelALU width; SHALL be at least 4.
REQ-003 Parameter TMO, default 15: FETCH cycles without mem_ack before a timeout fault; SHALL be 1..255.
REQ-004 Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-005 The block SHALL have one clock, clk; reset is asynchronous and active-low, named CLB.
REQ-006 clk  in  1  system clock, rising edge.
REQ-007 CLB  in  1  asynchronous active-low reset.
REQ-008 z, c  in  1 each  ACC zero flag and carry flag.
REQ-009 op  in  OP_W  opcode from IR.
REQ-010 mem_ack  in  1  instruction memory data valid.
REQ-011 mem_req  out  1  instruction fetch request.
REQ-012 LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc  out  1 each  datapath strobes.
REQ-013 SelAcc  out  2  ACC source: 00 = ALU, 10 = Reg, 11 = Imm.
REQ-014 SelALU  out  ALU_W  ALU operation, zero-extended op.
REQ-015 halted  out  1  HALT reached.
REQ-016 fault  out  2  00 = none, 01 = illegal op, 10 = fetch timeout.
REQ-017 retired  out  CNT_W  count of completed instructions.

Function
REQ-018 States SHALL be INIT, FETCH, DECODE, JUMP, ACC, REG, HALT and FAULT; every other encoding SHALL go to INIT on the next edge.
REQ-019 INIT SHALL go to FETCH after one cycle, with all outputs 0.
REQ-020 FETCH SHALL assert mem_req=1.
- mem_ack=1: LoadIR=1 and IncPC=1 in that same cycle; next state DECODE.
- mem_ack=0: stay in FETCH.
REQ-021 A timeout counter SHALL clear on FETCH entry and increment each FETCH cycle with mem_ack=0.
- When it reaches TMO (FETCH cycle TMO+1 with mem_ack=0) the next state SHALL be FAULT with fault=10.
- mem_ack=1 in that same cycle SHALL win: go to DECODE.
REQ-022 DECODE SHALL assert no strobes and SHALL branch on op:
- ADD 0001, SUB 0010, NOR 0011, MOVR 0100, SHL 1011, SHR 1100, LDIM 1101 -> ACC.
- MOVA 0101 -> REG.
- JZRS 0110, JZIM 0111 -> JUMP if z=1, else FETCH.
- JCRS 1000, JCIM 1010 -> JUMP if c=1, else FETCH.
- NOP 0000 -> FETCH.
- HALT 1111 -> HALT.
- Any other op, or any nonzero op bit above bit 3 -> FAULT with fault=01.
REQ-023 z and c SHALL be sampled only in DECODE; a not-taken jump SHALL retire with no LoadPC.
REQ-024 JUMP SHALL assert LoadPC=1 for one cycle, with SelPC=1 for JZRS/JCRS and SelPC=0 for JZIM/JCIM; next state FETCH.
REQ-025 ACC SHALL assert LoadAcc=1 and SelALU=op for one cycle, with SelAcc=10 for MOVR, 11 for LDIM and 00 otherwise; next state FETCH.
REQ-026 REG SHALL assert LoadReg=1 for one cycle; next state FETCH.
REQ-027 HALT and FAULT SHALL be terminal until CLB, with all strobes 0; halted=1 only in HALT.
REQ-028 fault SHALL hold its code while in FAULT and be 00 in every other state.
REQ-029 Every output SHALL be assigned in every state with no inferred latches; outputs not listed for a state SHALL be 0.
REQ-030 retired SHALL increment by 1, wrapping modulo 2^CNT_W, on the edge leaving JUMP, ACC or REG, and on the edge leaving DECODE for NOP, not-taken jumps and HALT.
REQ-031 Latency: ALU and MOV ops take 3 cycles with zero-wait fetch; taken jumps take 3; NOP and not-taken jumps take 2.

Reset
REQ-032 CLB=0 SHALL asynchronously force state=INIT, timeout counter=0, retired=0 and fault=00, and drive all strobes, mem_req and halted to 0, including mid-instruction and in HALT or FAULT.
REQ-033 After CLB deasserts, the first FETCH SHALL occur on the second rising edge.

Structure
REQ-034 Package ctrl_pkg SHALL hold the opcode constants, state encodings, SelAcc codes and fault codes.
REQ-035 Opcode classification (class, legality, SelPC, SelAcc) SHALL live in combinational sub-module ctrl_decode, instantiated once.

Verification
REQ-036 The bench SHALL cover these scenarios:
- CLB low 2 cycles, mem_ack=1, op=ADD -> FETCH, DECODE, ACC; LoadAcc=1, SelAcc=00, SelALU=0001; retired=1.
- op=JZRS: z=1 -> LoadPC=1 and SelPC=1; z=0 -> back to FETCH, LoadPC never 1, retired still increments.
- mem_ack low 3 cycles then high -> mem_req high 4 cycles, LoadIR only in cycle 4; with TMO=3 and ack never high -> fault=10.
- op=1001 -> FAULT, fault=01, all strobes 0 thereafter; CLB pulse -> INIT and fault=00.
- op=HALT -> halted=1, retired unchanged afterwards; CLB asserted during ACC -> LoadAcc drops immediately.
- CNT_W=4 with 16 NOPs -> retired wraps to 0.
